miner_noc_endpoint: RTL and testbench
=====================================

// Module: miner_noc_endpoint
// PURPOSE
//  NoC-side endpoint for one mining node, downstream of the block-header controller.
//  - Receives the 10-flit, 640-bit block header from the CONNECT network.
//  - Returns one credit per consumed flit.
//  - Hands the assembled header to the local hash core over a valid/ready handshake.
//  - Sends a one-flit result message back to the controller node.
// PARAMETERS
//  FLIT_DATA_WIDTH  64  payload bits per flit
//  DEST_BITS        5   destination field width
//  VC_BITS          2   virtual-channel field width
//  HDR_FLITS        10  flits per header (HDR_W = HDR_FLITS*FLIT_DATA_WIDTH = 640)
//  MY_ID            1   this node's NoC address
//  CTRL_ID          0   controller's NoC address (destination of result flits)
//  CREDIT_INIT      16  initial/maximum outbound credits (= FLIT_BUFFER_DEPTH)
// PORTS
//  CLK            in   1     clock; all logic on posedge
//  reset          in   1     synchronous, active-high reset
//  getFlit        in   FW    FW=2+64+DEST_BITS+VC_BITS=73: [72]valid [71]tail [70:66]dest [65:64]vc [63:0]data
//  EN_getFlit     out  1     dequeue strobe for getFlit
//  putCredits     out  1+VC  {valid, vc}, returned per consumed flit
//  EN_putCredits  out  1     qualifies putCredits
//  putFlit        out  FW    result flit, same layout as getFlit
//  EN_putFlit     out  1     qualifies putFlit
//  getCredits     in   1+VC  {valid, vc}, credit returning from network
//  EN_getCredits  out  1     credit dequeue strobe
//  hdr_data       out  640   assembled header; flit k data lands in hdr_data[64k+:64]
//  hdr_valid      out  1     header available to hash core
//  hdr_ready      in   1     hash core accepts header
//  res_valid      in   1     hash core result available
//  res_found      in   1     1 = golden nonce found, 0 = nonce range exhausted
//  res_ready      out  1     endpoint accepts result
//  err_seq        out  1     sticky: framing error seen (cleared only by reset)
// BEHAVIOUR
//  Reset values: all outputs 0 except EN_getCredits; out_credits=CREDIT_INIT; flit_cnt=0; state=RX.
//  EN_getCredits is 1 in every cycle after reset deasserts (always sinks credits).
//  FSM:
//   RX -> HAND_OFF after the flit with flit_cnt==HDR_FLITS-1 and tail=1 is accepted.
//   HAND_OFF -> WAIT_RES on hdr_valid && hdr_ready.
//   WAIT_RES -> SEND on res_valid && res_ready.
//   SEND -> RX when the result flit is issued.
//  RX:
//   - EN_getFlit=1; a flit is consumed when getFlit[72]=1.
//   - Consumed flit: write data to slot flit_cnt, then increment flit_cnt.
//   - Next cycle: EN_putCredits=1, putCredits={1'b1, consumed vc}, for exactly one cycle per flit.
//  Framing errors (flit still credited, err_seq set, flit_cnt -> 0, partial header dropped, stay in RX):
//   - tail=1 with flit_cnt<HDR_FLITS-1;
//   - tail=0 with flit_cnt==HDR_FLITS-1;
//   - dest!=MY_ID.
//  HAND_OFF:
//   - hdr_valid=1 starting the cycle after the tail is accepted.
//   - hdr_data stays stable while hdr_valid && !hdr_ready.
//   - EN_getFlit=0: further flits back-pressure in the network.
//  WAIT_RES: res_ready=1; result captured on res_valid.
//  SEND result flit: valid=1, tail=1, dest=CTRL_ID, vc=0, data=res_found ? 64'h1 : 64'h2.
//   - out_credits>=1: EN_putFlit=1 for one cycle, decrement out_credits, go to RX.
//   - out_credits==0: EN_putFlit=0; stay in SEND until a credit arrives.
//  Outside SEND, EN_putFlit=0.
//  Credit accounting:
//   - getCredits[VC_BITS]=1 increments out_credits, saturating at CREDIT_INIT.
//   - Arrival in the same cycle as a send leaves out_credits unchanged.
//  Reset mid-operation: partial header, pending result and any pending credit return are discarded.
// TESTING
//  1. 10 flits (dest=1, vc=0, tail on #10, data k=64'hk) -> hdr_data[64k+:64]=k.
//     Also 10 single-cycle EN_putCredits pulses; hdr_valid rises 1 cycle after flit 10.
//  2. Hold hdr_ready=0 for 20 cycles -> hdr_valid stays 1, hdr_data stable, EN_getFlit=0.
//     Release -> state WAIT_RES.
//  3. res_valid=1 with res_found=1 -> next cycle putFlit={1,1,5'd0,2'd0,64'h1}, EN_putFlit=1.
//     out_credits goes 16->15.
//  4. Drain out_credits to 0, then present a result -> no EN_putFlit.
//     Inject one getCredits={1,2'b00} -> flit sent the following cycle.
//  5. Tail on flit 4 -> err_seq=1, flit 4 credited, hdr_valid stays 0.
//     A following clean 10-flit header is assembled correctly.
//  6. Assert reset after 6 flits -> all outputs at reset values.
//     A fresh 10-flit header is accepted and stored from slot 0.

Source files
------------

// File: rtl/miner_noc_endpoint.sv
// NoC endpoint for one mining node: assembles the block header from flits,
// hands it to the hash core and returns a one-flit result to the controller.
module miner_noc_endpoint #(
  parameter int FLIT_DATA_WIDTH = 64,
  parameter int DEST_BITS       = 5,
  parameter int VC_BITS         = 2,
  parameter int HDR_FLITS       = 10,
  parameter int MY_ID           = 1,
  parameter int CTRL_ID         = 0,
  parameter int CREDIT_INIT     = 16,
  localparam int FW    = 2 + FLIT_DATA_WIDTH + DEST_BITS + VC_BITS,
  localparam int HDR_W = HDR_FLITS * FLIT_DATA_WIDTH
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [FW-1:0]      getFlit,
  output logic               EN_getFlit,
  output logic [VC_BITS:0]   putCredits,
  output logic               EN_putCredits,
  output logic [FW-1:0]      putFlit,
  output logic               EN_putFlit,
  input  logic [VC_BITS:0]   getCredits,
  output logic               EN_getCredits,
  output logic [HDR_W-1:0]   hdr_data,
  output logic               hdr_valid,
  input  logic               hdr_ready,
  input  logic               res_valid,
  input  logic               res_found,
  output logic               res_ready,
  output logic               err_seq
);

  localparam int CNT_W = $clog2(HDR_FLITS);
  localparam int CRW   = $clog2(CREDIT_INIT + 1);
  localparam logic [DEST_BITS-1:0] MY_DEST   = DEST_BITS'(MY_ID);
  localparam logic [DEST_BITS-1:0] CTRL_DEST = DEST_BITS'(CTRL_ID);
  localparam logic [CNT_W-1:0]     LAST_CNT  = CNT_W'(HDR_FLITS - 1);
  localparam logic [CRW-1:0]       CR_MAX    = CRW'(CREDIT_INIT);

  typedef enum logic [1:0] {
    RX,
    HAND_OFF,
    WAIT_RES,
    SEND
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]           flit_cnt;
  logic [CRW-1:0]             out_credits;
  logic                       found_q;
  logic                       take;
  logic                       last;
  logic                       frame_err;
  logic                       f_valid;
  logic                       f_tail;
  logic [DEST_BITS-1:0]       f_dest;
  logic [VC_BITS-1:0]         f_vc;
  logic [FLIT_DATA_WIDTH-1:0] f_data;
  logic                       cr_in;
  logic                       unused_bits;

  assign f_valid = getFlit[FW-1];
  assign f_tail  = getFlit[FW-2];
  assign f_dest  = getFlit[FW-3 -: DEST_BITS];
  assign f_vc    = getFlit[FLIT_DATA_WIDTH +: VC_BITS];
  assign f_data  = getFlit[FLIT_DATA_WIDTH-1:0];

  assign last      = (flit_cnt == LAST_CNT);
  assign frame_err = (f_tail != last) || (f_dest != MY_DEST);

  // Credits are always sunk; their vc field carries no information here.
  assign EN_getCredits = 1'b1;
  assign cr_in         = getCredits[VC_BITS];
  assign unused_bits   = ^getCredits[VC_BITS-1:0];

  always_comb begin
    state_n    = state;
    EN_getFlit = 1'b0;
    take       = 1'b0;
    hdr_valid  = 1'b0;
    res_ready  = 1'b0;
    EN_putFlit = 1'b0;
    putFlit    = '0;
    unique case (state)
      RX: begin
        EN_getFlit = !reset;
        take       = !reset && f_valid;
        if (take && !frame_err && last)
          state_n = HAND_OFF;
      end
      HAND_OFF: begin
        hdr_valid = 1'b1;
        if (hdr_ready)
          state_n = WAIT_RES;
      end
      WAIT_RES: begin
        res_ready = 1'b1;
        if (res_valid)
          state_n = SEND;
      end
      SEND: begin
        putFlit = {1'b1, 1'b1, CTRL_DEST, {VC_BITS{1'b0}},
                   found_q ? FLIT_DATA_WIDTH'(1)
                           : FLIT_DATA_WIDTH'(2)};
        EN_putFlit = (out_credits != '0);
        if (EN_putFlit)
          state_n = RX;
      end
      default: state_n = RX;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state         <= RX;
      flit_cnt      <= '0;
      hdr_data      <= '0;
      err_seq       <= 1'b0;
      EN_putCredits <= 1'b0;
      putCredits    <= '0;
      found_q       <= 1'b0;
      out_credits   <= CR_MAX;
    end else begin
      state         <= state_n;
      EN_putCredits <= take;
      putCredits    <= take ? {1'b1, f_vc} : '0;
      if (take) begin
        if (frame_err) begin
          err_seq  <= 1'b1;
          flit_cnt <= '0;
        end else begin
          for (int k = 0; k < HDR_FLITS; k++)
            if (flit_cnt == CNT_W'(k))
              hdr_data[k*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH] <= f_data;
          flit_cnt <= last ? '0 : flit_cnt + 1'b1;
        end
      end
      if (res_ready && res_valid)
        found_q <= res_found;
      // A send and an arrival in the same cycle cancel out.
      case ({cr_in, EN_putFlit})
        2'b10: if (out_credits < CR_MAX) out_credits <= out_credits + 1'b1;
        2'b01: out_credits <= out_credits - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_miner_noc_endpoint.sv
// Scoreboard bench for miner_noc_endpoint: directed header/result traffic,
// expected responses queued by stimulus and checked by output monitors.
module tb_miner_noc_endpoint;

  logic         CLK = 1'b0;
  logic         reset;
  logic [72:0]  getFlit;
  logic         EN_getFlit;
  logic [2:0]   putCredits;
  logic         EN_putCredits;
  logic [72:0]  putFlit;
  logic         EN_putFlit;
  logic [2:0]   getCredits;
  logic         EN_getCredits;
  logic [639:0] hdr_data;
  logic         hdr_valid;
  logic         hdr_ready;
  logic         res_valid;
  logic         res_found;
  logic         res_ready;
  logic         err_seq;

  int checks = 0;
  int errors = 0;
  int cred_model = 16;

  logic [2:0]   exp_cred[$];
  logic [72:0]  exp_flit[$];
  logic [639:0] exp_hdr[$];

  miner_noc_endpoint dut (
    .CLK(CLK), .reset(reset),
    .getFlit(getFlit), .EN_getFlit(EN_getFlit),
    .putCredits(putCredits), .EN_putCredits(EN_putCredits),
    .putFlit(putFlit), .EN_putFlit(EN_putFlit),
    .getCredits(getCredits), .EN_getCredits(EN_getCredits),
    .hdr_data(hdr_data), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .res_valid(res_valid), .res_found(res_found), .res_ready(res_ready),
    .err_seq(err_seq)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [639:0] act,
                     input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop and compare whenever the DUT presents an output.
  always @(negedge CLK) begin
    if (EN_putCredits) begin
      if (exp_cred.size() == 0) begin
        checks++; errors++;
        $display("FAIL credit_unexpected: got %0h", putCredits);
      end else chk("credit", 640'(putCredits), 640'(exp_cred.pop_front()));
    end
    if (EN_putFlit) begin
      if (exp_flit.size() == 0) begin
        checks++; errors++;
        $display("FAIL flit_unexpected: got %0h", putFlit);
      end else chk("put_flit", 640'(putFlit), 640'(exp_flit.pop_front()));
    end
    if (hdr_valid && hdr_ready) begin
      if (exp_hdr.size() == 0) begin
        checks++; errors++;
        $display("FAIL hdr_unexpected: got %0h", hdr_data);
      end else chk("hdr_data", hdr_data, exp_hdr.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic send_flit(input logic tail, input logic [4:0] dest,
                           input logic [1:0] vc, input logic [63:0] data);
    getFlit = {1'b1, tail, dest, vc, data};
    exp_cred.push_back({1'b1, vc});
    @(posedge CLK); #1;
    getFlit = '0;
  endtask

  task automatic send_header(input logic [63:0] base);
    logic [639:0] h;
    for (int k = 0; k < 10; k++) begin
      h[64*k +: 64] = base + 64'(k);
      if (k == 9) chk("hdr_valid_before_tail", 640'(hdr_valid), 640'(0));
      send_flit(k == 9, 5'd1, 2'(k % 3), base + 64'(k));
    end
    chk("hdr_valid_after_tail", 640'(hdr_valid), 640'(1));
    exp_hdr.push_back(h);
  endtask

  task automatic hand_off();
    hdr_ready = 1'b1;
    @(posedge CLK); #1;
    hdr_ready = 1'b0;
    chk("res_ready_wait", 640'(res_ready), 640'(1));
  endtask

  task automatic do_result(input logic found, input logic cr_on_send);
    res_valid = 1'b1;
    res_found = found;
    @(posedge CLK); #1;
    res_valid = 1'b0;
    res_found = 1'b0;
    if (cred_model > 0) begin
      exp_flit.push_back({1'b1, 1'b1, 5'd0, 2'd0, found ? 64'h1 : 64'h2});
      if (cr_on_send) getCredits = 3'b100;
      @(posedge CLK); #1;
      getCredits = '0;
      if (!cr_on_send) cred_model--;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge CLK);
    chk({tag, "_en_getflit"}, 640'(EN_getFlit), 640'(0));
    chk({tag, "_en_putcred"}, 640'(EN_putCredits), 640'(0));
    chk({tag, "_putcred"}, 640'(putCredits), 640'(0));
    chk({tag, "_en_putflit"}, 640'(EN_putFlit), 640'(0));
    chk({tag, "_putflit"}, 640'(putFlit), 640'(0));
    chk({tag, "_hdr_valid"}, 640'(hdr_valid), 640'(0));
    chk({tag, "_hdr_data"}, hdr_data, 640'(0));
    chk({tag, "_res_ready"}, 640'(res_ready), 640'(0));
    chk({tag, "_err_seq"}, 640'(err_seq), 640'(0));
    chk({tag, "_en_getcred"}, 640'(EN_getCredits), 640'(1));
    chk({tag, "_credits"}, 640'(dut.out_credits), 640'(16));
  endtask

  initial begin
    reset = 1'b1;
    getFlit = '0;
    getCredits = '0;
    hdr_ready = 1'b0;
    res_valid = 1'b0;
    res_found = 1'b0;
    repeat (3) @(posedge CLK);
    check_reset_outputs("reset");
    @(posedge CLK); #1;
    reset = 1'b0;

    // 1: basic header, data k in slot k
    send_header(64'h0);

    // 2: hash core stalls; a stray flit must stay in the network
    getFlit = {1'b1, 1'b1, 5'd1, 2'd0, 64'hdead};
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("stall_hdr_valid", 640'(hdr_valid), 640'(1));
      chk("stall_en_getflit", 640'(EN_getFlit), 640'(0));
      chk("stall_hdr_stable", hdr_data, exp_hdr[0]);
    end
    @(posedge CLK); #1;
    getFlit = '0;
    hand_off();

    // 3: golden nonce result
    do_result(1'b1, 1'b0);
    chk("credits_after_send", 640'(dut.out_credits), 640'(cred_model));

    // 4: drain credits, then stall for lack of a credit
    for (int i = 0; i < 15; i++) begin
      send_header(64'(i) << 8);
      hand_off();
      do_result(i[0], 1'b0);
    end
    chk("credits_drained", 640'(dut.out_credits), 640'(0));
    send_header(64'h5000);
    hand_off();
    do_result(1'b0, 1'b0);
    repeat (5) begin
      @(negedge CLK);
      chk("no_credit_no_send", 640'(EN_putFlit), 640'(0));
    end
    @(posedge CLK); #1;
    getCredits = 3'b100;
    exp_flit.push_back({1'b1, 1'b1, 5'd0, 2'd0, 64'h2});
    @(posedge CLK); #1;
    getCredits = '0;
    @(posedge CLK); #1;
    chk("flit_sent_after_credit", 640'(exp_flit.size()), 640'(0));
    chk("credits_zero_again", 640'(dut.out_credits), 640'(0));
    chk("back_to_rx", 640'(EN_getFlit), 640'(1));

    // credit saturation and simultaneous arrival/send
    getCredits = 3'b100;
    repeat (20) @(posedge CLK);
    #1;
    getCredits = '0;
    cred_model = 16;
    chk("credits_saturate", 640'(dut.out_credits), 640'(16));
    send_header(64'h6000);
    hand_off();
    do_result(1'b1, 1'b1);
    chk("credits_same_cycle", 640'(dut.out_credits), 640'(16));

    // 5: tail on flit 4
    for (int k = 0; k < 3; k++) send_flit(1'b0, 5'd1, 2'd1, 64'h77);
    send_flit(1'b1, 5'd1, 2'd2, 64'h77);
    chk("err_tail_early", 640'(err_seq), 640'(1));
    @(negedge CLK);
    chk("err_no_hdr_valid", 640'(hdr_valid), 640'(0));
    @(posedge CLK); #1;
    send_header(64'h100);
    hand_off();
    do_result(1'b1, 1'b0);

    // 6: reset after 6 flits
    for (int k = 0; k < 6; k++) send_flit(1'b0, 5'd1, 2'd0, 64'hbad);
    @(posedge CLK); #1;
    reset = 1'b1;
    cred_model = 16;
    @(posedge CLK);
    check_reset_outputs("midreset");
    @(posedge CLK); #1;
    reset = 1'b0;
    send_header(64'h200);
    chk("no_err_after_reset", 640'(err_seq), 640'(0));
    hand_off();
    do_result(1'b0, 1'b0);

    // wrong destination
    send_flit(1'b0, 5'd3, 2'd0, 64'h1);
    chk("err_bad_dest", 640'(err_seq), 640'(1));
    @(posedge CLK); #1;
    reset = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b0;
    cred_model = 16;

    // missing tail on flit 10
    for (int k = 0; k < 10; k++) send_flit(1'b0, 5'd1, 2'd0, 64'h9);
    chk("err_no_tail", 640'(err_seq), 640'(1));
    @(negedge CLK);
    chk("err_no_tail_hdr_valid", 640'(hdr_valid), 640'(0));
    @(posedge CLK); #1;
    send_header(64'h300);
    hand_off();

    for (int i = 0; i < 10; i++) begin
      if (exp_cred.size() == 0 && exp_flit.size() == 0 && exp_hdr.size() == 0)
        break;
      @(posedge CLK);
    end
    #1;
    chk("cred_queue_empty", 640'(exp_cred.size()), 640'(0));
    chk("flit_queue_empty", 640'(exp_flit.size()), 640'(0));
    chk("hdr_queue_empty", 640'(exp_hdr.size()), 640'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
